// File: rtl/rst_call_sequencer.sv
// Restart/interrupt call sequencer: arbitrates RST, NMI and INT, pushes the
// return PC onto the stack, then loads PC/SP and maintains IFF1/IFF2.
module rst_call_sequencer #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] INT_VECTOR = 16'h0038,
  parameter logic [ADDR_W-1:0] NMI_VECTOR = 16'h0066
) (
  input  logic              clk,
  input  logic              not_rst,
  input  logic              rst_req,
  input  logic [2:0]        rst_vec,
  input  logic              instr_boundary,
  input  logic              int_req,
  input  logic              nmi_req,
  input  logic              ei,
  input  logic              di,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] sp,
  input  logic              mem_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              pc_wr,
  output logic [ADDR_W-1:0] pc_wdata,
  output logic              sp_wr,
  output logic [ADDR_W-1:0] sp_wdata,
  output logic              int_ack,
  output logic              nmi_ack,
  output logic              busy,
  output logic              iff1,
  output logic              iff2
);

  typedef enum logic [1:0] {IDLE = 2'd0, PUSH_HI = 2'd1, PUSH_LO = 2'd2, JUMP = 2'd3} state_t;
  typedef enum logic [1:0] {SRC_RST = 2'd0, SRC_NMI = 2'd1, SRC_INT = 2'd2} src_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  state_t            state_r;
  src_t              src_r;
  logic [ADDR_W-1:0] pc_snap_r;
  logic [ADDR_W-1:0] sp_snap_r;
  logic [ADDR_W-1:0] target_r;
  logic              nmi_prev_r;
  logic              nmi_pending_r;
  logic              ei_shadow_r;

  logic              start_s;
  src_t              src_s;
  logic [ADDR_W-1:0] target_s;
  logic              nmi_rise_s;

  assign nmi_rise_s = nmi_req & ~nmi_prev_r;

  // Start arbitration in IDLE: RST beats NMI beats INT; interrupts only at boundaries.
  always_comb begin
    start_s  = 1'b0;
    src_s    = SRC_RST;
    target_s = {{(ADDR_W-6){1'b0}}, rst_vec, 3'b000};
    if (state_r != IDLE) begin
      start_s = 1'b0;
    end else if (rst_req) begin
      start_s = 1'b1;
    end else if (instr_boundary && nmi_pending_r) begin
      start_s  = 1'b1;
      src_s    = SRC_NMI;
      target_s = NMI_VECTOR;
    end else if (instr_boundary && int_req && iff1 && !ei_shadow_r) begin
      start_s  = 1'b1;
      src_s    = SRC_INT;
      target_s = INT_VECTOR;
    end else begin
      start_s = 1'b0;
    end
  end

  // Sequencer FSM, NMI edge latch, EI shadow and interrupt-enable flags.
  always_ff @(posedge clk or negedge not_rst) begin
    if (!not_rst) begin
      state_r       <= IDLE;
      src_r         <= SRC_RST;
      pc_snap_r     <= '0;
      sp_snap_r     <= '0;
      target_r      <= '0;
      nmi_prev_r    <= 1'b0;
      nmi_pending_r <= 1'b0;
      ei_shadow_r   <= 1'b0;
      mem_wr        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 8'h00;
      pc_wr         <= 1'b0;
      pc_wdata      <= '0;
      sp_wr         <= 1'b0;
      sp_wdata      <= '0;
      int_ack       <= 1'b0;
      nmi_ack       <= 1'b0;
      busy          <= 1'b0;
      iff1          <= 1'b0;
      iff2          <= 1'b0;
    end else begin
      nmi_prev_r <= nmi_req;

      if (nmi_rise_s) begin
        nmi_pending_r <= 1'b1;
      end else if (start_s && src_s == SRC_NMI) begin
        nmi_pending_r <= 1'b0;
      end else begin
        nmi_pending_r <= nmi_pending_r;
      end

      if (ei) begin
        ei_shadow_r <= 1'b1;
      end else if (instr_boundary) begin
        ei_shadow_r <= 1'b0;
      end else begin
        ei_shadow_r <= ei_shadow_r;
      end

      // The JUMP-state flag update below overrides EI/DI in the same cycle.
      if (di) begin
        iff1 <= 1'b0;
        iff2 <= 1'b0;
      end else if (ei) begin
        iff1 <= 1'b1;
        iff2 <= 1'b1;
      end else begin
        iff1 <= iff1;
        iff2 <= iff2;
      end

      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r   <= PUSH_HI;
            src_r     <= src_s;
            target_r  <= target_s;
            pc_snap_r <= pc;
            sp_snap_r <= sp;
            busy      <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= sp - ONE;
            mem_wdata <= pc[ADDR_W-1 -: 8];
          end else begin
            state_r <= IDLE;
          end
        end
        PUSH_HI: begin
          if (mem_ready) begin
            state_r   <= PUSH_LO;
            mem_addr  <= sp_snap_r - TWO;
            mem_wdata <= pc_snap_r[7:0];
          end else begin
            state_r <= PUSH_HI;
          end
        end
        PUSH_LO: begin
          if (mem_ready) begin
            state_r   <= JUMP;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            pc_wr     <= 1'b1;
            pc_wdata  <= target_r;
            sp_wr     <= 1'b1;
            sp_wdata  <= sp_snap_r - TWO;
            int_ack   <= (src_r == SRC_INT);
            nmi_ack   <= (src_r == SRC_NMI);
          end else begin
            state_r <= PUSH_LO;
          end
        end
        JUMP: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          pc_wr   <= 1'b0;
          sp_wr   <= 1'b0;
          int_ack <= 1'b0;
          nmi_ack <= 1'b0;
          case (src_r)
            SRC_INT: begin
              iff1 <= 1'b0;
              iff2 <= 1'b0;
            end
            SRC_NMI: begin
              iff1 <= 1'b0;
              iff2 <= iff1;
            end
            default: begin
            end
          endcase
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          mem_wr  <= 1'b0;
          pc_wr   <= 1'b0;
          sp_wr   <= 1'b0;
          int_ack <= 1'b0;
          nmi_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_call_sequencer.sv
// Directed self-checking bench for rst_call_sequencer; inputs change #1 after
// the rising edge and registered outputs are checked at that same point.
module tb_rst_call_sequencer;

  logic        clk = 1'b0;
  logic        not_rst;
  logic        rst_req;
  logic [2:0]  rst_vec;
  logic        instr_boundary;
  logic        int_req;
  logic        nmi_req;
  logic        ei;
  logic        di;
  logic [15:0] pc;
  logic [15:0] sp;
  logic        mem_ready;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        pc_wr;
  logic [15:0] pc_wdata;
  logic        sp_wr;
  logic [15:0] sp_wdata;
  logic        int_ack;
  logic        nmi_ack;
  logic        busy;
  logic        iff1;
  logic        iff2;

  int n_checks = 0;
  int n_fail   = 0;

  rst_call_sequencer dut (
    .clk(clk), .not_rst(not_rst), .rst_req(rst_req), .rst_vec(rst_vec),
    .instr_boundary(instr_boundary), .int_req(int_req), .nmi_req(nmi_req),
    .ei(ei), .di(di), .pc(pc), .sp(sp), .mem_ready(mem_ready),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc_wr(pc_wr), .pc_wdata(pc_wdata), .sp_wr(sp_wr), .sp_wdata(sp_wdata),
    .int_ack(int_ack), .nmi_ack(nmi_ack), .busy(busy), .iff1(iff1), .iff2(iff2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    not_rst = 1'b0; rst_req = 1'b0; rst_vec = 3'd0; instr_boundary = 1'b0;
    int_req = 1'b0; nmi_req = 1'b0; ei = 1'b0; di = 1'b0;
    pc = 16'h0000; sp = 16'h0000; mem_ready = 1'b1;
    step(); step();
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pc_wr", {31'd0, pc_wr}, 32'd0);
    check("rst_iffs", {30'd0, iff1, iff2}, 32'd0);
    not_rst = 1'b1;
    step();

    // RST 5 from pc=1234 sp=8000, zero wait states; inputs change after start.
    rst_req = 1'b1; rst_vec = 3'd5; pc = 16'h1234; sp = 16'h8000;
    step();
    rst_req = 1'b0; pc = 16'hFFFF; sp = 16'h0000;
    check("r5_hi_wr", {31'd0, mem_wr}, 32'd1);
    check("r5_hi_busy", {31'd0, busy}, 32'd1);
    check("r5_hi_addr", {16'd0, mem_addr}, 32'h7FFF);
    check("r5_hi_data", {24'd0, mem_wdata}, 32'h12);
    step();
    check("r5_lo_wr", {31'd0, mem_wr}, 32'd1);
    check("r5_lo_addr", {16'd0, mem_addr}, 32'h7FFE);
    check("r5_lo_data", {24'd0, mem_wdata}, 32'h34);
    step();
    check("r5_j_flags", {26'd0, mem_wr, pc_wr, sp_wr, busy, int_ack, nmi_ack}, 32'b011100);
    check("r5_j_pc", {16'd0, pc_wdata}, 32'h0028);
    check("r5_j_sp", {16'd0, sp_wdata}, 32'h7FFE);
    step();
    check("r5_done", {29'd0, busy, pc_wr, sp_wr}, 32'd0);

    // Same call with two wait states in PUSH_HI.
    rst_req = 1'b1; pc = 16'h1234; sp = 16'h8000; mem_ready = 1'b0;
    step();
    rst_req = 1'b0;
    check("ws_c1_addr", {16'd0, mem_addr}, 32'h7FFF);
    step();
    check("ws_c2_hold", {15'd0, mem_wr, mem_addr, mem_wdata}, {15'd0, 1'b1, 16'h7FFF, 8'h12});
    step();
    check("ws_c3_hold", {15'd0, mem_wr, mem_addr, mem_wdata}, {15'd0, 1'b1, 16'h7FFF, 8'h12});
    mem_ready = 1'b1;
    step();
    check("ws_c4_lo", {15'd0, mem_wr, mem_addr, mem_wdata}, {15'd0, 1'b1, 16'h7FFE, 8'h34});
    check("ws_c4_nojump", {31'd0, pc_wr}, 32'd0);
    step();
    check("ws_c5_jump", {31'd0, pc_wr}, 32'd1);
    check("ws_c5_pc", {16'd0, pc_wdata}, 32'h0028);
    step();

    // EI shadow: INT masked at the first boundary after EI, taken at the next.
    ei = 1'b1; instr_boundary = 1'b1;
    step();
    ei = 1'b0;
    check("ei_iffs", {30'd0, iff1, iff2}, 32'b11);
    int_req = 1'b1;
    step();
    instr_boundary = 1'b0;
    check("ei_shadow_blocks", {31'd0, busy}, 32'd0);
    step();
    check("no_boundary_no_int", {31'd0, busy}, 32'd0);
    instr_boundary = 1'b1; pc = 16'h4000; sp = 16'h9000;
    step();
    instr_boundary = 1'b0; int_req = 1'b0;
    check("int_hi", {16'd0, mem_addr}, 32'h8FFF);
    check("int_hi_data", {24'd0, mem_wdata}, 32'h40);
    step(); step();
    check("int_j_pc", {16'd0, pc_wdata}, 32'h0038);
    check("int_j_ack", {30'd0, int_ack, nmi_ack}, 32'b10);
    check("int_j_iff_hold", {30'd0, iff1, iff2}, 32'b11);
    step();
    check("int_after", {28'd0, int_ack, busy, iff1, iff2}, 32'd0);

    // NMI edge during a busy RST 3, taken at the next boundary.
    ei = 1'b1;
    step();
    ei = 1'b0; instr_boundary = 1'b1;
    step();
    instr_boundary = 1'b0;
    check("nmi_pre_iff1", {31'd0, iff1}, 32'd1);
    rst_req = 1'b1; rst_vec = 3'd3; pc = 16'h2222; sp = 16'h3000;
    step();
    rst_req = 1'b0; nmi_req = 1'b1;
    step();
    nmi_req = 1'b0;
    step();
    check("nmi_rst_pc", {16'd0, pc_wdata}, 32'h0018);
    check("nmi_rst_noack", {31'd0, nmi_ack}, 32'd0);
    step();
    step();
    check("nmi_waits_boundary", {31'd0, busy}, 32'd0);
    instr_boundary = 1'b1; pc = 16'h5555; sp = 16'h6000;
    step();
    instr_boundary = 1'b0;
    check("nmi_start", {31'd0, busy}, 32'd1);
    step(); step();
    check("nmi_j_pc", {16'd0, pc_wdata}, 32'h0066);
    check("nmi_j_sp", {16'd0, sp_wdata}, 32'h5FFE);
    check("nmi_j_ack", {30'd0, int_ack, nmi_ack}, 32'b01);
    step();
    check("nmi_iffs", {30'd0, iff1, iff2}, 32'b01);
    instr_boundary = 1'b1;
    step();
    instr_boundary = 1'b0;
    check("nmi_pending_cleared", {31'd0, busy}, 32'd0);

    // SP wrap via RST 0; an RST strobe while busy must be ignored.
    rst_req = 1'b1; rst_vec = 3'd0; pc = 16'hABCD; sp = 16'h0001;
    step();
    rst_vec = 3'd7;
    check("wrap_hi", {8'd0, mem_addr, mem_wdata}, {8'd0, 16'h0000, 8'hAB});
    step();
    rst_req = 1'b0;
    check("wrap_lo", {8'd0, mem_addr, mem_wdata}, {8'd0, 16'hFFFF, 8'hCD});
    step();
    check("wrap_sp", {16'd0, sp_wdata}, 32'hFFFF);
    check("wrap_pc", {16'd0, pc_wdata}, 32'h0000);
    step();
    step();
    check("busy_rst_ignored", {31'd0, busy}, 32'd0);

    // EI and DI together: DI wins.
    ei = 1'b1; di = 1'b1;
    step();
    ei = 1'b0; di = 1'b0;
    check("ei_di_di_wins", {30'd0, iff1, iff2}, 32'd0);

    // Reset asserted mid PUSH_LO aborts at once.
    ei = 1'b1;
    step();
    ei = 1'b0; rst_req = 1'b1; pc = 16'h7777; sp = 16'h7000;
    step();
    rst_req = 1'b0;
    step();
    check("pre_abort_lo", {16'd0, mem_addr}, 32'h6FFE);
    not_rst = 1'b0;
    #1;
    check("abort_now", {26'd0, mem_wr, pc_wr, sp_wr, busy, iff1, iff2}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_pc_wr", {31'd0, pc_wr}, 32'd0);
    end
    not_rst = 1'b1;
    step(); step();
    check("after_abort", {29'd0, busy, pc_wr, mem_wr}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_call_sequencer.md
Name: rst_call_sequencer

Overview:
Multi-cycle controller for the restart/interrupt call path. It takes the one-cycle RST decode strobe and 3-bit vector from the CINT0/RST decoder, plus the maskable INT and NMI requests. It arbitrates between these sources and sequences the two-byte PC push onto the stack. It then loads PC with the restart or interrupt vector and updates SP, and it owns the IFF1/IFF2 interrupt-enable flip-flops.

Parameters:
ADDR_W, 16, address/PC/SP width
INT_VECTOR, 16'h0038, PC target for an accepted maskable INT (IM1-style)
NMI_VECTOR, 16'h0066, PC target for an accepted NMI

Ports:
clk  in  1  system clock, all state on rising edge
not_rst  in  1  asynchronous active-low reset
rst_req  in  1  one-cycle strobe: RST instruction decoded (decoder enable_cint)
rst_vec  in  3  RST index n; target = n*8 (0x00..0x38)
instr_boundary  in  1  high in the last cycle of an instruction; interrupt sampling point
int_req  in  1  maskable interrupt request, level-sensitive
nmi_req  in  1  non-maskable request, rising-edge-sensitive
ei  in  1  one-cycle strobe from EI execution
di  in  1  one-cycle strobe from DI execution
pc  in  ADDR_W  current PC (return address)
sp  in  ADDR_W  current SP
mem_ready  in  1  memory accepted the current write
mem_wr  out  1  memory write request
mem_addr  out  ADDR_W  write address
mem_wdata  out  8  write data
pc_wr  out  1  one-cycle PC load
pc_wdata  out  ADDR_W  new PC
sp_wr  out  1  one-cycle SP load
sp_wdata  out  ADDR_W  new SP
int_ack  out  1  one-cycle acknowledge of accepted INT
nmi_ack  out  1  one-cycle acknowledge of accepted NMI
busy  out  1  sequence in progress; core must stall fetch
iff1  out  1  interrupt enable flag 1
iff2  out  1  interrupt enable flag 2

Behaviour:
- Reset (not_rst=0, async):
  - state=IDLE; every output 0, including iff1/iff2.
  - nmi_pending=0, ei_shadow=0.
  - A reset mid-sequence aborts immediately; no further mem_wr/pc_wr/sp_wr.
- States: IDLE -> PUSH_HI -> PUSH_LO -> JUMP -> IDLE.
- Start in IDLE, priority order:
  1. rst_req: source=RST, target={0..,rst_vec,3'b000}.
  2. instr_boundary & nmi_pending: source=NMI.
  3. instr_boundary & int_req & iff1 & !ei_shadow: source=INT.
- Start actions:
  - Snapshot pc, sp and target into registers.
  - busy=1 from the next cycle.
  - rst_req together with instr_boundary: RST wins; interrupts stay pending for the next boundary.
- NMI latching:
  - A rising edge of nmi_req sets nmi_pending in any state, including busy.
  - nmi_pending clears on the cycle an NMI sequence starts.
- PUSH_HI:
  - mem_wr=1, mem_addr=sp_snap-1 (mod 2^ADDR_W), mem_wdata=pc_snap[15:8].
  - Hold all three while mem_ready=0; advance on mem_ready=1.
- PUSH_LO:
  - mem_addr=sp_snap-2, mem_wdata=pc_snap[7:0].
  - Same hold/advance rule as PUSH_HI.
- JUMP (exactly one cycle):
  - pc_wr=1, pc_wdata=target; sp_wr=1, sp_wdata=sp_snap-2; mem_wr=0.
  - INT: int_ack=1; iff1=iff2=0 next cycle.
  - NMI: nmi_ack=1; iff2<=iff1 (unchanged), iff1=0.
  - RST: flags unchanged.
- Latency: 3 cycles from start to end of JUMP with zero wait states; +1 per mem_ready-low cycle.
- busy=1 in PUSH_HI, PUSH_LO and JUMP.
- SP arithmetic wraps: sp=0x0001 pushes to 0x0000 then 0xFFFF, sp_wdata=0xFFFF.
- EI/DI:
  - ei sets iff1=iff2=1 and sets ei_shadow for one instruction; ei_shadow clears at the next instr_boundary.
  - di clears both flags.
  - ei and di together: di wins.
  - ei/di coincident with JUMP of INT/NMI: sequencer flag update wins.
- rst_req/int_req while busy are ignored; int_req is level, so it is re-evaluated at the next boundary.
- No combinational path from inputs to mem_*/pc_*/sp_*; all come from registered state.

Test Plan:
- Reset mid-PUSH_LO -> outputs 0 immediately, iff1/iff2=0, no pc_wr ever issued.
- rst_req=1, rst_vec=3'b101, pc=0x1234, sp=0x8000, mem_ready=1 -> writes 0x12@0x7FFF then 0x34@0x7FFE; pc_wdata=0x0028, sp_wdata=0x7FFE; busy high for 3 cycles.
- Same as previous with mem_ready low 2 cycles in PUSH_HI -> addr/data held stable; JUMP occurs 5 cycles after start.
- ei, then int_req=1 at the next boundary -> not accepted; accepted at the following boundary: pc_wdata=0x0038, int_ack pulse, iff1=iff2=0.
- NMI edge during busy RST sequence; iff1=1 -> after RST completes, NMI taken at next boundary: pc_wdata=0x0066, nmi_ack, iff1=0, iff2=1.
- sp=0x0001, pc=0xABCD via RST 0 -> writes 0xAB@0x0000, 0xCD@0xFFFF; sp_wdata=0xFFFF, pc_wdata=0x0000.
